// File: rtl/cp0_reg_unit.sv
// ---------------------------------------------------------------------------
// cp0_reg_unit
//
// Purpose:
//   MIPS-style coprocessor-0 register file. Holds Count, Compare, Status,
//   Cause, EPC and the read-only Config/PRId constants. It also raises a
//   registered timer interrupt when Count reaches a non-zero Compare.
//
// Ports:
//   clk          single pipeline clock; all state updates on its rising edge
//   rst          synchronous active-high reset
//   we_i         CP0 write enable from write-back
//   waddr_i      CP0 register number being written
//   data_i       CP0 write data
//   raddr_i      CP0 register number being read (mfc0 in execute)
//   int_i        external hardware interrupt lines, sampled into Cause[15:10]
//   data_o       combinational read data for raddr_i, with write bypass
//   count_o ..
//   prid_o       current register contents
//   timer_int_o  registered timer interrupt request
// ---------------------------------------------------------------------------
module cp0_reg_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] data_i,
  input  logic [4:0]  raddr_i,
  input  logic [5:0]  int_i,
  output logic [31:0] data_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] config_o,
  output logic [31:0] prid_o,
  output logic        timer_int_o
);

  localparam logic [4:0]  ADDR_COUNT   = 5'd9;
  localparam logic [4:0]  ADDR_COMPARE = 5'd11;
  localparam logic [4:0]  ADDR_STATUS  = 5'd12;
  localparam logic [4:0]  ADDR_CAUSE   = 5'd13;
  localparam logic [4:0]  ADDR_EPC     = 5'd14;
  localparam logic [4:0]  ADDR_PRID    = 5'd15;
  localparam logic [4:0]  ADDR_CONFIG  = 5'd16;

  localparam logic [31:0] CONFIG_VAL   = 32'h0000_8000;
  localparam logic [31:0] PRID_VAL     = 32'h004C_0102;
  localparam logic [31:0] STATUS_RST   = 32'h1000_0000;

  // Software-writable Cause bits: IV (23), WP (22) and IP[1:0] (9:8).
  localparam logic [31:0] CAUSE_WMASK  = 32'h00C0_0300;

  logic [31:0] count_q,   count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] status_q,  status_d;
  logic [31:0] cause_q,   cause_d;
  logic [31:0] epc_q,     epc_d;
  logic        timer_q,   timer_d;

  logic        wr_count;
  logic        wr_compare;
  logic        wr_status;
  logic        wr_cause;
  logic        wr_epc;
  logic        bypass;
  logic [31:0] cause_merged;

  assign wr_count   = we_i && (waddr_i == ADDR_COUNT);
  assign wr_compare = we_i && (waddr_i == ADDR_COMPARE);
  assign wr_status  = we_i && (waddr_i == ADDR_STATUS);
  assign wr_cause   = we_i && (waddr_i == ADDR_CAUSE);
  assign wr_epc     = we_i && (waddr_i == ADDR_EPC);

  // Cause as it would look after a software write: writable bits from
  // data_i, everything else (including the sampled IP[7:2]) kept.
  assign cause_merged = (cause_q & ~CAUSE_WMASK) | (data_i & CAUSE_WMASK);

  always_comb begin
    count_d   = count_q + 32'd1;
    compare_d = compare_q;
    status_d  = status_q;
    cause_d   = cause_q;
    epc_d     = epc_q;
    timer_d   = timer_q;

    if (wr_count)   count_d   = data_i;
    if (wr_compare) compare_d = data_i;
    if (wr_status)  status_d  = data_i;
    if (wr_epc)     epc_d     = data_i;
    if (wr_cause)   cause_d   = cause_merged;

    // Hardware interrupt lines overwrite IP[7:2] every cycle, whether or
    // not software is writing Cause.
    cause_d[15:10] = int_i;

    // A Compare write acknowledges the timer and beats a same-cycle match.
    // Compare == 0 is treated as "timer disabled".
    if (wr_compare) begin
      timer_d = 1'b0;
    end else if ((compare_q != 32'd0) && (count_q == compare_q)) begin
      timer_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      status_q  <= STATUS_RST;
      cause_q   <= 32'd0;
      epc_q     <= 32'd0;
      timer_q   <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      status_q  <= status_d;
      cause_q   <= cause_d;
      epc_q     <= epc_d;
      timer_q   <= timer_d;
    end
  end

  // Read port. When the same register is being written this cycle the
  // value it will hold after the edge is forwarded, so mfc0 directly after
  // mtc0 needs no stall. Config/PRId are constants and never forwarded.
  assign bypass = we_i && (waddr_i == raddr_i);

  always_comb begin
    data_o = 32'd0;
    case (raddr_i)
      ADDR_COUNT:   data_o = bypass ? data_i : count_q;
      ADDR_COMPARE: data_o = bypass ? data_i : compare_q;
      ADDR_STATUS:  data_o = bypass ? data_i : status_q;
      ADDR_CAUSE:   data_o = bypass ? cause_merged : cause_q;
      ADDR_EPC:     data_o = bypass ? data_i : epc_q;
      ADDR_PRID:    data_o = PRID_VAL;
      ADDR_CONFIG:  data_o = CONFIG_VAL;
      default:      data_o = 32'd0;
    endcase
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign status_o    = status_q;
  assign cause_o     = cause_q;
  assign epc_o       = epc_q;
  assign config_o    = CONFIG_VAL;
  assign prid_o      = PRID_VAL;
  assign timer_int_o = timer_q;

endmodule

// File: tb/tb_cp0_reg_unit.sv
// ---------------------------------------------------------------------------
// tb_cp0_reg_unit
//
// Self-checking bench for cp0_reg_unit. A behavioural model of the CP0
// register set is advanced once per clock edge from the same inputs that
// drive the DUT; outputs are compared on the falling edge. Directed
// sequences cover the timer, Count wrap, Cause masking/bypass and reset,
// followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_cp0_reg_unit;

  logic        clk;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] data_i;
  logic [4:0]  raddr_i;
  logic [5:0]  int_i;
  logic [31:0] data_o;
  logic [31:0] count_o;
  logic [31:0] compare_o;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic [31:0] config_o;
  logic [31:0] prid_o;
  logic        timer_int_o;

  int checks;
  int failures;

  // Reference model state
  logic [31:0] m_count, m_compare, m_status, m_cause, m_epc;
  logic        m_timer;
  bit          model_valid;
  logic [31:0] last_data_o;

  cp0_reg_unit dut (
    .clk         (clk),
    .rst         (rst),
    .we_i        (we_i),
    .waddr_i     (waddr_i),
    .data_i      (data_i),
    .raddr_i     (raddr_i),
    .int_i       (int_i),
    .data_o      (data_o),
    .count_o     (count_o),
    .compare_o   (compare_o),
    .status_o    (status_o),
    .cause_o     (cause_o),
    .epc_o       (epc_o),
    .config_o    (config_o),
    .prid_o      (prid_o),
    .timer_int_o (timer_int_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case anything ever stalls the main sequence.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Value the read port should show, derived from the architectural rules:
  // a register being written in this cycle reads as its post-edge value.
  function automatic logic [31:0] modelRead();
    logic [31:0] r;
    bit fwd;
    fwd = we_i && (waddr_i == raddr_i);
    case (raddr_i)
      5'd9:    r = fwd ? data_i : m_count;
      5'd11:   r = fwd ? data_i : m_compare;
      5'd12:   r = fwd ? data_i : m_status;
      5'd13:   r = fwd ? ((m_cause & ~32'h00C00300) | (data_i & 32'h00C00300)) : m_cause;
      5'd14:   r = fwd ? data_i : m_epc;
      5'd15:   r = 32'h004C0102;
      5'd16:   r = 32'h00008000;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Advance the model across one rising edge.
  task automatic modelClock();
    if (rst) begin
      m_count   = 32'd0;
      m_compare = 32'd0;
      m_status  = 32'h10000000;
      m_cause   = 32'd0;
      m_epc     = 32'd0;
      m_timer   = 1'b0;
      model_valid = 1'b1;
    end else begin
      if (we_i && waddr_i == 5'd11)
        m_timer = 1'b0;
      else if (m_compare != 0 && m_count == m_compare)
        m_timer = 1'b1;
      if (we_i && waddr_i == 5'd9) m_count = data_i;
      else                         m_count = m_count + 1;
      if (we_i && waddr_i == 5'd11) m_compare = data_i;
      if (we_i && waddr_i == 5'd12) m_status  = data_i;
      if (we_i && waddr_i == 5'd14) m_epc     = data_i;
      if (we_i && waddr_i == 5'd13)
        m_cause = (m_cause & ~32'h00C00300) | (data_i & 32'h00C00300);
      m_cause[15:10] = int_i;
    end
  endtask

  task automatic checkOutput();
    if (model_valid) begin
      checkVal("count",   count_o,   m_count);
      checkVal("compare", compare_o, m_compare);
      checkVal("status",  status_o,  m_status);
      checkVal("cause",   cause_o,   m_cause);
      checkVal("epc",     epc_o,     m_epc);
      checkVal("config",  config_o,  32'h00008000);
      checkVal("prid",    prid_o,    32'h004C0102);
      checkVal("timer",   {31'd0, timer_int_o}, {31'd0, m_timer});
      checkVal("data_o",  data_o,    modelRead());
    end
  endtask

  // One clock cycle: drive on the falling edge, check, then advance the
  // model at the rising edge.
  task automatic applyStimulus(input logic r, input logic we, input logic [4:0] wa,
                               input logic [31:0] d, input logic [4:0] ra,
                               input logic [5:0] iv);
    @(negedge clk);
    rst = r; we_i = we; waddr_i = wa; data_i = d; raddr_i = ra; int_i = iv;
    #1;
    checkOutput();
    last_data_o = data_o;
    @(posedge clk);
    modelClock();
  endtask

  task automatic idle(input logic [4:0] ra);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, ra, 6'd0);
  endtask

  initial begin
    logic [4:0] addrs [8];
    logic [4:0] wa;
    logic [31:0] d;
    checks = 0;
    failures = 0;
    model_valid = 1'b0;
    rst = 1'b0; we_i = 1'b0; waddr_i = '0; data_i = '0; raddr_i = '0; int_i = '0;

    // Reset then five idle cycles
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 5'd16, 6'd0);
    for (int i = 0; i < 5; i++) idle(5'd15);
    #2;
    checkVal("rst_count5",  count_o,  32'd5);
    checkVal("rst_status",  status_o, 32'h10000000);
    checkVal("rst_timer",   {31'd0, timer_int_o}, 32'd0);

    // Timer: Compare = 0x10, run past the match
    applyStimulus(1'b0, 1'b1, 5'd11, 32'h10, 5'd11, 6'd0);
    for (int i = 0; i < 40 && m_count != 32'h11; i++) idle(5'd9);
    #2;
    checkVal("timer_rise_cnt", count_o, 32'h11);
    checkVal("timer_rise",     {31'd0, timer_int_o}, 32'd1);
    idle(5'd12);
    #2;
    checkVal("timer_hold",     {31'd0, timer_int_o}, 32'd1);
    applyStimulus(1'b0, 1'b1, 5'd11, 32'h20, 5'd0, 6'd0);
    #2;
    checkVal("timer_clear",    {31'd0, timer_int_o}, 32'd0);

    // Count wrap
    applyStimulus(1'b0, 1'b1, 5'd9, 32'hFFFFFFFE, 5'd9, 6'd0);
    idle(5'd9);
    #2;
    checkVal("wrap_ffff", count_o, 32'hFFFFFFFF);
    idle(5'd9);
    #2;
    checkVal("wrap_zero", count_o, 32'h00000000);
    idle(5'd9);
    #2;
    checkVal("wrap_one",  count_o, 32'h00000001);

    // Cause write mask, interrupt sampling and read bypass
    applyStimulus(1'b0, 1'b1, 5'd13, 32'hFFFFFFFF, 5'd13, 6'b101010);
    checkVal("cause_bypass", last_data_o, 32'h00C00300);
    #2;
    checkVal("cause_write",  cause_o, 32'h00C0AB00);

    // Compare write wins over a same-cycle match
    applyStimulus(1'b0, 1'b1, 5'd9, 32'h20, 5'd0, 6'd0);
    applyStimulus(1'b0, 1'b1, 5'd11, 32'h80, 5'd11, 6'd0);
    #2;
    checkVal("cmp_wins", {31'd0, timer_int_o}, 32'd0);

    // Reset discards a pending timer and a simultaneous EPC write
    applyStimulus(1'b0, 1'b1, 5'd9, 32'h7E, 5'd0, 6'd0);
    for (int i = 0; i < 10 && !m_timer; i++) idle(5'd14);
    #2;
    checkVal("timer_pre_rst", {31'd0, timer_int_o}, 32'd1);
    applyStimulus(1'b1, 1'b1, 5'd14, 32'h1234, 5'd14, 6'b111111);
    #2;
    checkVal("rst_timer_drop", {31'd0, timer_int_o}, 32'd0);
    checkVal("rst_epc",        epc_o, 32'd0);
    checkVal("rst_cause",      cause_o, 32'd0);

    // Randomized phase
    addrs[0] = 5'd9;  addrs[1] = 5'd11; addrs[2] = 5'd12; addrs[3] = 5'd13;
    addrs[4] = 5'd14; addrs[5] = 5'd15; addrs[6] = 5'd16; addrs[7] = 5'd0;
    for (int i = 0; i < 400; i++) begin
      wa = addrs[$urandom_range(0, 7)];
      if (wa == 5'd0) wa = 5'($urandom);
      d = $urandom;
      if (wa == 5'd11) d = m_count + 32'($urandom_range(0, 4));
      else if (wa == 5'd9 && $urandom_range(0, 1) == 1) d = m_compare - 32'($urandom_range(0, 3));
      applyStimulus(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) == 0), wa, d,
                    ($urandom_range(0, 1) == 1) ? wa : 5'($urandom),
                    6'($urandom));
    end
    idle(5'd13);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cp0_reg_unit.md
CP0_REG_UNIT -- requirements
Module: cp0_reg_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset (rst == `RstEnable == 1'b1), sampled only on the rising edge of clk.
REQ-002 clk  input  1  the single pipeline clock; every register updates on its rising edge.
REQ-003 rst  input  1  synchronous reset, active high.
REQ-004 we_i  input  1  CP0 write enable, driven by the write-back stage (wb_cp0_reg_we).
REQ-005 waddr_i  input  5  CP0 write register number (wb_cp0_reg_write_addr).
REQ-006 data_i  input  32  CP0 write data (wb_cp0_reg_data).
REQ-007 raddr_i  input  5  CP0 read register number, driven by the execute stage (mfc0).
REQ-008 int_i  input  6  external hardware interrupt lines, level sensitive.
REQ-009 data_o  output  32  read data for raddr_i; combinational.
REQ-010 count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o  output  32 each  current register contents.
REQ-011 timer_int_o  output  1  timer interrupt request, registered.

Function
REQ-012 Register numbers SHALL be: Count 9, Compare 11, Status 12, Cause 13, EPC 14, PRId 15, Config 16; a write to any other number SHALL be ignored.
REQ-013 Count SHALL increment by 1 every non-reset cycle and wrap from 0xFFFFFFFF to 0x00000000.
REQ-014 A write to Count SHALL load data_i in place of the increment for that cycle.
REQ-015 A write to Compare SHALL load data_i and clear timer_int_o on the same edge.
REQ-016 When Compare != 0, Count == Compare and no Compare write occurs in that cycle, timer_int_o SHALL be set on the next edge and stay 1 until a Compare write or reset.
REQ-017 If a Compare write and a Count == Compare match occur in the same cycle, the write SHALL win: timer_int_o is 0 afterwards.
REQ-018 Status and EPC SHALL accept full 32-bit writes.
REQ-019 A Cause write SHALL update only IP[1:0] (bits 9:8), WP (bit 22) and IV (bit 23); all other Cause bits SHALL ignore data_i.
REQ-020 Cause[15:10] SHALL be loaded from int_i every non-reset cycle, irrespective of writes.
REQ-021 Config and PRId SHALL be read-only constants: Config = 0x00008000, PRId = 0x004C0102.
REQ-022 data_o SHALL return the register selected by raddr_i, or 0x00000000 for an unimplemented number.
REQ-023 Read bypass: when we_i = 1 and waddr_i == raddr_i, data_o SHALL return the value the register takes on the next edge. Count and Status return data_i. Cause returns its current value with bits 9:8, 22 and 23 replaced from data_i.
REQ-024 Writes to Config and PRId SHALL not be bypassed.
REQ-025 Read-to-data_o latency SHALL be 0 cycles. Write-to-register latency SHALL be 1 edge.

Reset
REQ-026 On rst = 1 the block SHALL reset: Count 0, Compare 0, Status 0x10000000 (CU0 = 1), Cause 0, EPC 0, and timer_int_o to 0.
REQ-027 Reset SHALL dominate any simultaneous write, increment or interrupt sampling.
REQ-028 Reset asserted mid-operation SHALL discard a pending timer interrupt.
REQ-029 After reset, data_o for Config/PRId SHALL read the constants of REQ-021.

Verification
REQ-030 Reset then 5 idle cycles -> count_o = 5, status_o = 0x10000000, timer_int_o = 0.
REQ-031 Write Compare = 0x10, then let Count run -> timer_int_o rises the edge after count_o == 0x10 and stays 1. Next, write Compare = 0x20 -> timer_int_o = 0 after that edge.
REQ-032 Write Count = 0xFFFFFFFE -> count_o reads 0xFFFFFFFF, then 0x00000000, then 0x00000001 on successive cycles.
REQ-033 Write Cause = 0xFFFFFFFF with int_i = 6'b101010 -> cause_o = 0x00C0AB00. Also check: raddr_i = 13 in the write cycle -> data_o shows the bypassed bits 9:8, 22 and 23.
REQ-034 Write Count with Compare already equal to Count, then write Compare in the match cycle -> timer_int_o stays 0.
REQ-035 Assert rst while timer_int_o = 1 and we_i = 1 (EPC, 0x1234) -> after the edge, timer_int_o = 0 and epc_o = 0.
